// File: rtl/ibex_hpm_ctrl.sv
// HPM control stage: event selection, inhibit, counter write strobes and CSR read mux.
// Optional overflow flags (mhpmovf at 0x7C0) when IBEX_HPM_OVERFLOW_EN is defined.
module ibex_hpm_ctrl #(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned EventWidth   = 16,
  parameter int unsigned CounterWidth = 40
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      csr_re_i,
  input  logic                      csr_we_i,
  input  logic [11:0]               csr_addr_i,
  input  logic [31:0]               csr_wdata_i,
  output logic [31:0]               csr_rdata_o,
  output logic                      csr_illegal_o,
  input  logic [EventWidth-1:0]     events_i,
  input  logic [64*NumCounters-1:0] counter_val_i,
  output logic [NumCounters-1:0]    counter_inc_o,
  output logic [NumCounters-1:0]    counter_we_o,
  output logic [NumCounters-1:0]    counterh_we_o,
  output logic [31:0]               counter_wdata_o,
  output logic [31:0]               mcountinhibit_o,
  output logic                      overflow_o
);

  function automatic logic [31:0] gen_inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int i = 0; i < int'(NumCounters); i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] InhMask = gen_inh_mask();

  logic [EventWidth-1:0]  events_q, events_d;
  logic [EventWidth-1:0]  mhpmevent_q [NumCounters];
  logic [EventWidth-1:0]  mhpmevent_d [NumCounters];
  logic [31:0]            mcountinhibit_q, mcountinhibit_d;

  logic                   inh_hit;
  logic [NumCounters-1:0] evt_hit, cnt_hit, cnth_hit;
  logic [31:0]            cnt_lo [NumCounters];
  logic [31:0]            cnt_hi [NumCounters];

  assign inh_hit         = (csr_addr_i == 12'h320);
  assign counter_wdata_o = csr_wdata_i;
  assign mcountinhibit_o = mcountinhibit_q;

  for (genvar gi = 0; gi < NumCounters; gi++) begin : g_cnt
    localparam logic [11:0] EvtAddr  = 12'h323 + 12'(gi);
    localparam logic [11:0] CntAddr  = 12'hB03 + 12'(gi);
    localparam logic [11:0] CnthAddr = 12'hB83 + 12'(gi);

    assign evt_hit[gi]  = (csr_addr_i == EvtAddr);
    assign cnt_hit[gi]  = (csr_addr_i == CntAddr);
    assign cnth_hit[gi] = (csr_addr_i == CnthAddr);

    assign counter_we_o[gi]  = csr_we_i & cnt_hit[gi];
    assign counterh_we_o[gi] = csr_we_i & cnth_hit[gi];

    // A counter write in the same cycle takes priority over the increment.
    assign counter_inc_o[gi] = ~mcountinhibit_q[3+gi] & (|(events_q & mhpmevent_q[gi]))
                             & ~counter_we_o[gi] & ~counterh_we_o[gi];

    assign cnt_lo[gi] = counter_val_i[64*gi +: 32];
    assign cnt_hi[gi] = counter_val_i[64*gi+32 +: 32];
  end

  always_comb begin
    events_d        = events_i;
    mcountinhibit_d = mcountinhibit_q;
    if (csr_we_i && inh_hit) mcountinhibit_d = csr_wdata_i & InhMask;
    for (int k = 0; k < int'(NumCounters); k++) begin
      mhpmevent_d[k] = mhpmevent_q[k];
      if (csr_we_i && evt_hit[k]) mhpmevent_d[k] = csr_wdata_i[EventWidth-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      events_q        <= '0;
      mcountinhibit_q <= '0;
      for (int k = 0; k < int'(NumCounters); k++) mhpmevent_q[k] <= '0;
    end else begin
      events_q        <= events_d;
      mcountinhibit_q <= mcountinhibit_d;
      for (int k = 0; k < int'(NumCounters); k++) mhpmevent_q[k] <= mhpmevent_d[k];
    end
  end

`ifdef IBEX_HPM_OVERFLOW_EN
  logic                   ovf_hit;
  logic [NumCounters-1:0] ovf_q, ovf_d, ovf_clr, cnt_wrap;

  assign ovf_hit = (csr_addr_i == 12'h7C0);

  for (genvar gi = 0; gi < NumCounters; gi++) begin : g_wrap
    assign cnt_wrap[gi] = &counter_val_i[64*gi +: CounterWidth];
  end

  // Set is applied after the W1C clear so a simultaneous wrap is never lost.
  always_comb begin
    ovf_clr = '0;
    if (csr_we_i && ovf_hit) ovf_clr = csr_wdata_i[3 +: NumCounters];
    ovf_d = (ovf_q & ~ovf_clr) | (counter_inc_o & cnt_wrap);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= '0;
    else         ovf_q <= ovf_d;
  end

  assign overflow_o = |ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  always_comb begin
    logic owned;
    csr_rdata_o = '0;
    owned       = inh_hit;
    if (inh_hit) csr_rdata_o = mcountinhibit_q;
    for (int k = 0; k < int'(NumCounters); k++) begin
      if (evt_hit[k])  csr_rdata_o = 32'(mhpmevent_q[k]);
      if (cnt_hit[k])  csr_rdata_o = cnt_lo[k];
      if (cnth_hit[k]) csr_rdata_o = cnt_hi[k];
      owned = owned | evt_hit[k] | cnt_hit[k] | cnth_hit[k];
    end
`ifdef IBEX_HPM_OVERFLOW_EN
    if (ovf_hit) csr_rdata_o = 32'(ovf_q) << 3;
    owned = owned | ovf_hit;
`endif
    csr_illegal_o = (csr_re_i | csr_we_i) & ~owned;
  end

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
// Self-checking bench for ibex_hpm_ctrl: directed vector table, reset and overflow
// sequences, and randomized traffic checked against a behavioural model.
module tb_ibex_hpm_ctrl;
  localparam int N  = 4;
  localparam int EW = 16;
  localparam int CW = 40;
`ifdef IBEX_HPM_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            csr_re_i, csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [31:0]     csr_wdata_i;
  logic [31:0]     csr_rdata_o;
  logic            csr_illegal_o;
  logic [EW-1:0]   events_i;
  logic [64*N-1:0] counter_val_i;
  logic [N-1:0]    counter_inc_o, counter_we_o, counterh_we_o;
  logic [31:0]     counter_wdata_o, mcountinhibit_o;
  logic            overflow_o;

  ibex_hpm_ctrl #(.NumCounters(N), .EventWidth(EW), .CounterWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_re_i(csr_re_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .events_i(events_i), .counter_val_i(counter_val_i),
    .counter_inc_o(counter_inc_o), .counter_we_o(counter_we_o),
    .counterh_we_o(counterh_we_o), .counter_wdata_o(counter_wdata_o),
    .mcountinhibit_o(mcountinhibit_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, exp);
    end
  endtask

  // Drives one cycle at posedge+1, checks at the falling edge, returns at next posedge+1.
  task automatic step(input string tag, input logic re, input logic we, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [EW-1:0] ev, input logic [64*N-1:0] cv,
                      input logic [N-1:0] e_inc, input logic [N-1:0] e_we, input logic [N-1:0] e_whe,
                      input logic [31:0] e_rd, input logic e_ill, input logic e_ovf,
                      input logic [31:0] e_inh);
    csr_re_i = re; csr_we_i = we; csr_addr_i = addr; csr_wdata_i = wd;
    events_i = ev; counter_val_i = cv;
    #4;
    chk(tag, "inc",     32'(counter_inc_o),  32'(e_inc));
    chk(tag, "we",      32'(counter_we_o),   32'(e_we));
    chk(tag, "whe",     32'(counterh_we_o),  32'(e_whe));
    chk(tag, "rdata",   csr_rdata_o,         e_rd);
    chk(tag, "illegal", 32'(csr_illegal_o),  32'(e_ill));
    chk(tag, "wdata",   counter_wdata_o,     wd);
    chk(tag, "ovf",     32'(overflow_o),     32'(e_ovf));
    chk(tag, "inhibit", mcountinhibit_o,     e_inh);
    $display("%s re=%0b we=%0b addr=%03h wd=%08h ev=%04h inc=%0h rd=%08h ill=%0b",
             tag, re, we, addr, wd, ev, counter_inc_o, csr_rdata_o, csr_illegal_o);
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic re; logic we; logic [11:0] addr; logic [31:0] wd; logic [EW-1:0] ev;
    logic [N-1:0] inc; logic [N-1:0] cwe; logic [N-1:0] chwe;
    logic [31:0] rd; logic ill; logic [31:0] inh;
  } vec_t;

  vec_t tbl[25];

  // Behavioural model state
  logic [31:0]   m_evt [N];
  logic [31:0]   m_inh;
  logic [EW-1:0] m_evq;
  logic [N-1:0]  m_ovf;

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_evt[k] = '0;
    m_inh = '0; m_evq = '0; m_ovf = '0;
  endtask

  task automatic do_idle_reset();
    csr_re_i = 0; csr_we_i = 0; csr_addr_i = '0; csr_wdata_i = '0;
    events_i = '0; counter_val_i = '0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [64*N-1:0] cv;
    logic [63:0]     lowmask;
    logic [31:0]     inh_mask;
    lowmask  = (64'd1 << CW) - 64'd1;
    inh_mask = 32'h5;
    for (int k = 0; k < N; k++) inh_mask[3+k] = 1'b1;

    tbl[0]  = '{1, 0, 12'h323, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[1]  = '{1, 0, 12'h320, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[2]  = '{1, 0, 12'hB03, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[3]  = '{0, 1, 12'h323, 32'h5,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[4]  = '{1, 0, 12'h323, 32'h0,        16'h4, 4'h0, 4'h0, 4'h0, 32'h5,    0, 32'h0};
    tbl[5]  = '{0, 0, 12'h000, 32'h0,        16'h0, 4'h1, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[6]  = '{0, 0, 12'h000, 32'h0,        16'h5, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[7]  = '{0, 0, 12'h000, 32'h0,        16'h0, 4'h1, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[8]  = '{0, 0, 12'h000, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[9]  = '{0, 1, 12'h320, 32'hFFFFFFFF, 16'h4, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[10] = '{1, 0, 12'h320, 32'h0,        16'h4, 4'h0, 4'h0, 4'h0, 32'h7D,   0, 32'h7D};
    tbl[11] = '{0, 1, 12'h320, 32'h0,        16'h4, 4'h0, 4'h0, 4'h0, 32'h7D,   0, 32'h7D};
    tbl[12] = '{0, 0, 12'h000, 32'h0,        16'h4, 4'h1, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[13] = '{0, 1, 12'hB83, 32'h12,       16'h0, 4'h0, 4'h0, 4'h1, 32'h0,    0, 32'h0};
    tbl[14] = '{0, 0, 12'h000, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[15] = '{1, 0, 12'h7FF, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    1, 32'h0};
    tbl[16] = '{0, 1, 12'hB07, 32'hFFFF,     16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    1, 32'h0};
    tbl[17] = '{0, 1, 12'hB03, 32'h3,        16'h0, 4'h0, 4'h1, 4'h0, 32'h0,    0, 32'h0};
    tbl[18] = '{0, 1, 12'hB86, 32'h3,        16'h0, 4'h0, 4'h0, 4'h8, 32'h0,    0, 32'h0};
    tbl[19] = '{0, 1, 12'h324, 32'hFFFFFFFF, 16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[20] = '{1, 0, 12'h324, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'hFFFF, 0, 32'h0};
    tbl[21] = '{0, 1, 12'h320, 32'h2,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[22] = '{1, 0, 12'h320, 32'h0,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[23] = '{0, 1, 12'h320, 32'h1,        16'h0, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h0};
    tbl[24] = '{0, 0, 12'h000, 32'h0,        16'h1, 4'h0, 4'h0, 4'h0, 32'h0,    0, 32'h1};

    do_idle_reset();
    for (int i = 0; i < 25; i++)
      step($sformatf("vec%0d", i), tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ev,
           '0, tbl[i].inc, tbl[i].cwe, tbl[i].chwe, tbl[i].rd, tbl[i].ill, 1'b0, tbl[i].inh);

    // Asynchronous reset mid-operation: pending event and inhibit must vanish at once.
    events_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst", "inc",     32'(counter_inc_o), 32'h0);
    chk("async_rst", "inhibit", mcountinhibit_o,    32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    model_reset();
    step("post_rst0", 1, 0, 12'h323, 32'h0, '0, '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("post_rst1", 1, 0, 12'h324, 32'h0, '0, '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);

    // Randomized traffic against the behavioural model.
    for (int t = 0; t < 1500; t++) begin
      logic re, we;
      logic [11:0] addr;
      logic [31:0] wd, e_rd;
      logic [EW-1:0] ev;
      logic [N-1:0] e_inc, e_we, e_whe;
      logic e_ill, owned;
      int r;
      re = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, N);
      case ($urandom_range(0, 5))
        0: addr = 12'h320;
        1: addr = 12'h323 + 12'(r);
        2: addr = 12'hB03 + 12'(r);
        3: addr = 12'hB83 + 12'(r);
        4: addr = 12'h7C0;
        default: addr = 12'($urandom);
      endcase
      wd = $urandom;
      ev = EW'($urandom & $urandom & $urandom);
      for (int k = 0; k < N; k++) begin
        cv[64*k +: 64] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) cv[64*k +: CW] = '1;
      end

      owned = 0; e_rd = 0;
      if (addr == 12'h320) begin owned = 1; e_rd = m_inh; end
      if (OvfEn && addr == 12'h7C0) begin owned = 1; e_rd = 32'(m_ovf) << 3; end
      for (int k = 0; k < N; k++) begin
        e_we[k]  = we && (addr == 12'hB03 + 12'(k));
        e_whe[k] = we && (addr == 12'hB83 + 12'(k));
        if (addr == 12'h323 + 12'(k)) begin owned = 1; e_rd = m_evt[k]; end
        if (addr == 12'hB03 + 12'(k)) begin owned = 1; e_rd = cv[64*k +: 32]; end
        if (addr == 12'hB83 + 12'(k)) begin owned = 1; e_rd = cv[64*k+32 +: 32]; end
        e_inc[k] = !m_inh[3+k] && ((32'(m_evq) & m_evt[k]) != 0) && !e_we[k] && !e_whe[k];
      end
      e_ill = (re || we) && !owned;

      step($sformatf("rnd%0d", t), re, we, addr, wd, ev, cv, e_inc, e_we, e_whe,
           e_rd, e_ill, (m_ovf != 0), m_inh);

      m_evq = ev;
      if (we && addr == 12'h320) m_inh = wd & inh_mask;
      for (int k = 0; k < N; k++)
        if (we && addr == 12'h323 + 12'(k)) m_evt[k] = wd & ((32'd1 << EW) - 32'd1);
      if (OvfEn) begin
        if (we && addr == 12'h7C0) m_ovf = m_ovf & ~wd[3 +: N];
        for (int k = 0; k < N; k++)
          if (e_inc[k] && ((cv[64*k +: 64] & lowmask) == lowmask)) m_ovf[k] = 1'b1;
      end
    end

    // Overflow flag sequence.
    do_idle_reset();
    cv = '0;
    cv[CW-1:0] = '1;
`ifdef IBEX_HPM_OVERFLOW_EN
    step("ovf0", 0, 1, 12'h323, 32'h1, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf1", 0, 0, 12'h000, 32'h0, 16'h1, '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf2", 0, 0, 12'h000, 32'h0, '0,    cv, 4'h1, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf3", 1, 0, 12'h7C0, 32'h0, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h8, 0, 1, 32'h0);
    step("ovf4", 0, 1, 12'h7C0, 32'h8, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h8, 0, 1, 32'h0);
    step("ovf5", 1, 0, 12'h7C0, 32'h0, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
`else
    step("ovf0", 0, 1, 12'h323, 32'h1, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf1", 0, 0, 12'h000, 32'h0, 16'h1, '0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf2", 0, 0, 12'h000, 32'h0, '0,    cv, 4'h1, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    step("ovf3", 1, 0, 12'h7C0, 32'h0, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 32'h0);
    step("ovf4", 0, 1, 12'h7C0, 32'h8, '0,    '0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
